// File: rtl/pipe_sched.sv
// Pipeline scheduler: three-slot write scoreboard for RAW hazards in ID,
// branch sequencing for branches resolved in EX, and saturating stall/branch counters.
module pipe_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_wr,
    input  logic [4:0]       id_rw,
    input  logic             id_is_branch,
    input  logic             ex_branch_taken,
    output logic             if_stall,
    output logic             id_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BR_EX = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic       s_ex_v, s_mem_v, s_wr_v;
    logic [4:0] s_ex_rw, s_mem_rw, s_wr_rw;
    logic       rs_match, rt_match, hazard, issue;

    // No forwarding: any valid slot holding the source register blocks the read.
    assign rs_match = (s_ex_v  && (s_ex_rw  == id_rs)) ||
                      (s_mem_v && (s_mem_rw == id_rs)) ||
                      (s_wr_v  && (s_wr_rw  == id_rs));
    assign rt_match = (s_ex_v  && (s_ex_rw  == id_rt)) ||
                      (s_mem_v && (s_mem_rw == id_rt)) ||
                      (s_wr_v  && (s_wr_rw  == id_rt));
    assign hazard = id_valid &&
                    ((id_uses_rs && (id_rs != 5'd0) && rs_match) ||
                     (id_uses_rt && (id_rt != 5'd0) && rt_match));
    assign issue  = id_valid && (state == RUN) && !hazard;

    always_comb begin
        state_nx    = state;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    if_stall    = 1'b1;
                    id_stall    = 1'b1;
                    idex_bubble = 1'b1;
                end else if (issue && id_is_branch) begin
                    state_nx = BR_EX;
                end
            end
            BR_EX: begin
                if_stall    = 1'b1;
                id_stall    = 1'b1;
                idex_bubble = 1'b1;
                state_nx    = ex_branch_taken ? FLUSH : RUN;
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_nx    = RUN;
            end
            default: state_nx = RUN;
        endcase
        // Reset holds the pipeline in a nop-injecting state regardless of FSM state.
        if (reset) begin
            if_stall    = 1'b0;
            id_stall    = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end
    end

    // Updates on the same (falling) edge as the pipeline registers.
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= RUN;
            s_ex_v    <= 1'b0;
            s_mem_v   <= 1'b0;
            s_wr_v    <= 1'b0;
            stall_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            state    <= state_nx;
            s_wr_v   <= s_mem_v;
            s_wr_rw  <= s_mem_rw;
            s_mem_v  <= s_ex_v;
            s_mem_rw <= s_ex_rw;
            s_ex_v   <= issue && id_reg_wr && (id_rw != 5'd0);
            s_ex_rw  <= id_rw;
            if (idex_bubble && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if ((state == BR_EX) && ex_branch_taken && (taken_cnt != {CNT_W{1'b1}}))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule
